// File: rtl/iram_pkg.sv
// Shared definitions for the 8051 internal data memory controller:
// opcodes, FSM state encoding and fixed address-map constants.
package iram_pkg;

  localparam logic [1:0] OP_RD_BYTE = 2'b00;
  localparam logic [1:0] OP_WR_BYTE = 2'b01;
  localparam logic [1:0] OP_RD_BIT  = 2'b10;
  localparam logic [1:0] OP_WR_BIT  = 2'b11;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_RMW  = 2'd2
  } state_e;

  localparam logic [7:0] LRAM_TOP      = 8'h7F;
  localparam logic [7:0] BIT_AREA_BASE = 8'h20;
  localparam logic [7:0] SFR_BASE      = 8'h80;

endpackage

// File: rtl/iram_addr_decode.sv
// Combinational 8051 address decode.
// Outputs: storage space select, byte index, bit index, unimplemented-location indicator.
module iram_addr_decode
  import iram_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int IRAM_DEPTH = 256
) (
  input  logic [1:0]            op_i,
  input  logic                  indirect_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [7:0]            bit_addr_i,
  output logic                  sfr_sel_o,
  output logic [ADDR_WIDTH-1:0] byte_idx_o,
  output logic [2:0]            bit_idx_o,
  output logic                  unimpl_o
);

  logic is_bit;
  assign is_bit = (op_i == OP_RD_BIT) || (op_i == OP_WR_BIT);

  always_comb begin
    sfr_sel_o  = 1'b0;
    byte_idx_o = addr_i;
    bit_idx_o  = bit_addr_i[2:0];
    unimpl_o   = 1'b0;
    if (is_bit) begin
      // Bit addresses below 80h live in the 20h-2Fh bit area; above that
      // they address the bit-addressable SFRs (those ending in 0h or 8h).
      if (bit_addr_i < SFR_BASE) begin
        byte_idx_o = ADDR_WIDTH'(BIT_AREA_BASE) + ADDR_WIDTH'(bit_addr_i[6:3]);
      end else begin
        sfr_sel_o  = 1'b1;
        byte_idx_o = ADDR_WIDTH'({bit_addr_i[7:3], 3'b000});
      end
    end else if (addr_i > ADDR_WIDTH'(LRAM_TOP)) begin
      if (indirect_i) begin
        unimpl_o = (IRAM_DEPTH <= 128);
      end else begin
        sfr_sel_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/iram_ctrl.sv
// 8051 internal data memory: lower/upper RAM and SFR space behind a
// req/ready handshake, with a reset clear sweep and read-modify-write bit writes.
module iram_ctrl
  import iram_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 8,
  parameter int IRAM_DEPTH     = 256,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req,
  input  logic [1:0]            op,
  input  logic                  indirect,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [7:0]            bit_addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  wbit,
  output logic                  ready,
  output logic                  rvalid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rbit,
  output logic                  err,
  output logic                  init_done,
  output logic [1:0]            state_dbg
);

  localparam int IW = $clog2(IRAM_DEPTH);
  localparam int CW = $clog2(IRAM_DEPTH + 128);
  localparam logic [CW-1:0] CNT_SFR  = CW'(IRAM_DEPTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(IRAM_DEPTH + 127);

  logic [DATA_WIDTH-1:0] iram_q [IRAM_DEPTH];
  logic [DATA_WIDTH-1:0] sfr_q  [128];

  state_e                state_q, state_d;
  logic [CW-1:0]         clr_q, clr_d, clr_sfr;
  logic                  rvalid_q, rvalid_d, err_q, err_d, rbit_q, rbit_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  init_done_q, init_done_d;
  logic                  rmw_sfr_q, rmw_sfr_d, rmw_wbit_q, rmw_wbit_d;
  logic [ADDR_WIDTH-1:0] rmw_idx_q, rmw_idx_d;
  logic [2:0]            rmw_bit_q, rmw_bit_d;

  logic                  iram_we, sfr_we;
  logic [IW-1:0]         iram_waddr;
  logic [6:0]            sfr_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata, rd_byte, rmw_new;

  logic                  dec_sfr, dec_unimpl;
  logic [ADDR_WIDTH-1:0] dec_idx;
  logic [2:0]            dec_bit;

  iram_addr_decode #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .IRAM_DEPTH (IRAM_DEPTH)
  ) u_decode (
    .op_i       (op),
    .indirect_i (indirect),
    .addr_i     (addr),
    .bit_addr_i (bit_addr),
    .sfr_sel_o  (dec_sfr),
    .byte_idx_o (dec_idx),
    .bit_idx_o  (dec_bit),
    .unimpl_o   (dec_unimpl)
  );

  assign clr_sfr = clr_q - CNT_SFR;
  assign rd_byte = dec_sfr ? sfr_q[dec_idx[6:0]] : iram_q[dec_idx[IW-1:0]];

  // The RMW cycle reads the byte latched at acceptance straight from storage,
  // so an earlier write to the same byte is already visible here.
  always_comb begin
    rmw_new = rmw_sfr_q ? sfr_q[rmw_idx_q[6:0]] : iram_q[rmw_idx_q[IW-1:0]];
    rmw_new[rmw_bit_q] = rmw_wbit_q;
  end

  always_comb begin
    state_d     = state_q;
    clr_d       = clr_q;
    rvalid_d    = 1'b0;
    err_d       = 1'b0;
    rdata_d     = rdata_q;
    rbit_d      = rbit_q;
    init_done_d = init_done_q;
    rmw_sfr_d   = rmw_sfr_q;
    rmw_idx_d   = rmw_idx_q;
    rmw_bit_d   = rmw_bit_q;
    rmw_wbit_d  = rmw_wbit_q;
    iram_we     = 1'b0;
    sfr_we      = 1'b0;
    iram_waddr  = clr_q[IW-1:0];
    sfr_waddr   = clr_sfr[6:0];
    mem_wdata   = '0;
    case (state_q)
      ST_INIT: begin
        if (clr_q < CNT_SFR) iram_we = 1'b1;
        else                 sfr_we  = 1'b1;
        clr_d = clr_q + 1'b1;
        if (clr_q == CNT_LAST) begin
          state_d     = ST_IDLE;
          init_done_d = 1'b1;
        end
      end
      ST_IDLE: begin
        if (req) begin
          err_d = dec_unimpl;
          case (op)
            OP_RD_BYTE: begin
              rvalid_d = 1'b1;
              rdata_d  = dec_unimpl ? '0 : rd_byte;
            end
            OP_RD_BIT: begin
              rvalid_d = 1'b1;
              rbit_d   = rd_byte[dec_bit];
            end
            OP_WR_BYTE: begin
              mem_wdata  = wdata;
              iram_waddr = dec_idx[IW-1:0];
              sfr_waddr  = dec_idx[6:0];
              iram_we    = !dec_unimpl && !dec_sfr;
              sfr_we     = !dec_unimpl && dec_sfr;
            end
            default: begin
              rmw_sfr_d  = dec_sfr;
              rmw_idx_d  = dec_idx;
              rmw_bit_d  = dec_bit;
              rmw_wbit_d = wbit;
              state_d    = ST_RMW;
            end
          endcase
        end
      end
      ST_RMW: begin
        mem_wdata  = rmw_new;
        iram_waddr = rmw_idx_q[IW-1:0];
        sfr_waddr  = rmw_idx_q[6:0];
        iram_we    = !rmw_sfr_q;
        sfr_we     = rmw_sfr_q;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= (CLEAR_ON_RESET != 0) ? ST_INIT : ST_IDLE;
      init_done_q <= (CLEAR_ON_RESET == 0);
      clr_q       <= '0;
      rvalid_q    <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      rbit_q      <= 1'b0;
      rmw_sfr_q   <= 1'b0;
      rmw_idx_q   <= '0;
      rmw_bit_q   <= '0;
      rmw_wbit_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_done_q <= init_done_d;
      clr_q       <= clr_d;
      rvalid_q    <= rvalid_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      rbit_q      <= rbit_d;
      rmw_sfr_q   <= rmw_sfr_d;
      rmw_idx_q   <= rmw_idx_d;
      rmw_bit_q   <= rmw_bit_d;
      rmw_wbit_q  <= rmw_wbit_d;
    end
  end

  // Storage has no reset; a reset edge only suppresses the pending write.
  always_ff @(posedge clock) begin
    if (iram_we && !reset) iram_q[iram_waddr] <= mem_wdata;
    if (sfr_we && !reset)  sfr_q[sfr_waddr]   <= mem_wdata;
  end

  assign ready     = (state_q == ST_IDLE);
  assign rvalid    = rvalid_q;
  assign rdata     = rdata_q;
  assign rbit      = rbit_q;
  assign err       = err_q;
  assign init_done = init_done_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_iram_ctrl.sv
// Directed bench for iram_ctrl: a full-size instance driven from a vector table
// plus hand sequences, and a 128-byte instance for the missing upper RAM.
module tb_iram_ctrl;
  import iram_pkg::*;

  logic       clock = 1'b0;
  logic       reset;
  logic       req1, req2;
  logic [1:0] op;
  logic       indirect;
  logic [7:0] addr, bit_addr, wdata;
  logic       wbit;

  logic       ready1, rvalid1, rbit1, err1, init_done1;
  logic [7:0] rdata1;
  logic [1:0] state1;
  logic       ready2, rvalid2, rbit2, err2, init_done2;
  logic [7:0] rdata2;
  logic [1:0] state2;

  logic       tgt;
  logic       ready_m, rvalid_m, rbit_m, err_m;
  logic [7:0] rdata_m;

  int n_vec = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  iram_ctrl dut (
    .clock (clock), .reset (reset), .req (req1), .op (op), .indirect (indirect),
    .addr (addr), .bit_addr (bit_addr), .wdata (wdata), .wbit (wbit),
    .ready (ready1), .rvalid (rvalid1), .rdata (rdata1), .rbit (rbit1),
    .err (err1), .init_done (init_done1), .state_dbg (state1)
  );

  iram_ctrl #(.IRAM_DEPTH (128)) dut128 (
    .clock (clock), .reset (reset), .req (req2), .op (op), .indirect (indirect),
    .addr (addr), .bit_addr (bit_addr), .wdata (wdata), .wbit (wbit),
    .ready (ready2), .rvalid (rvalid2), .rdata (rdata2), .rbit (rbit2),
    .err (err2), .init_done (init_done2), .state_dbg (state2)
  );

  assign ready_m  = tgt ? ready2  : ready1;
  assign rvalid_m = tgt ? rvalid2 : rvalid1;
  assign rdata_m  = tgt ? rdata2  : rdata1;
  assign rbit_m   = tgt ? rbit2   : rbit1;
  assign err_m    = tgt ? err2    : err1;

  typedef struct {
    logic [1:0] op;
    logic       ind;
    logic [7:0] addr;
    logic [7:0] baddr;
    logic [7:0] wdata;
    logic       wbit;
    logic [7:0] exp_d;
    logic       exp_b;
    logic       exp_e;
  } vec_t;

  vec_t tbl[25];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; issues one request to the selected instance and
  // checks the response on the following negedge.
  task automatic do_op(input string name, input logic [1:0] o, input logic ind,
                       input logic [7:0] a, input logic [7:0] ba, input logic [7:0] wd,
                       input logic wb, input logic [7:0] exp_d, input logic exp_b,
                       input logic exp_e);
    int w = 0;
    while (!ready_m && w < 1000) begin
      @(negedge clock);
      w++;
    end
    if (!ready_m) begin
      chk({name, "_ready_timeout"}, 32'(ready_m), 32'd1);
      return;
    end
    op = o; indirect = ind; addr = a; bit_addr = ba; wdata = wd; wbit = wb;
    if (tgt) req2 = 1'b1;
    else     req1 = 1'b1;
    @(posedge clock);
    @(negedge clock);
    req1 = 1'b0;
    req2 = 1'b0;
    chk({name, "_rvalid"}, 32'(rvalid_m), 32'((o == OP_RD_BYTE) || (o == OP_RD_BIT)));
    chk({name, "_err"}, 32'(err_m), 32'(exp_e));
    if (o == OP_RD_BYTE) chk({name, "_rdata"}, 32'(rdata_m), 32'(exp_d));
    if (o == OP_RD_BIT)  chk({name, "_rbit"}, 32'(rbit_m), 32'(exp_b));
    if (o == OP_WR_BIT) begin
      chk({name, "_rmw_busy"}, 32'(ready_m), 32'd0);
      @(negedge clock);
      chk({name, "_rmw_done"}, 32'(ready_m), 32'd1);
    end
  endtask

  // Called at the negedge where reset is released; counts cycles until ready.
  task automatic wait_init(input string name);
    int c1 = 0;
    int c2 = 0;
    while ((!ready1 || !ready2) && c1 < 2000) begin
      if (!ready1) c1++;
      if (!ready2) c2++;
      @(negedge clock);
    end
    chk({name, "_init_cycles"}, 32'(c1), 32'd384);
    chk({name, "_init_cycles128"}, 32'(c2), 32'd256);
    chk({name, "_init_done"}, 32'(init_done1), 32'd1);
    chk({name, "_init_done128"}, 32'(init_done2), 32'd1);
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_ready"}, 32'(ready1), 32'd0);
    chk({name, "_rvalid"}, 32'(rvalid1), 32'd0);
    chk({name, "_rdata"}, 32'(rdata1), 32'd0);
    chk({name, "_rbit"}, 32'(rbit1), 32'd0);
    chk({name, "_err"}, 32'(err1), 32'd0);
    chk({name, "_init_done"}, 32'(init_done1), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{OP_RD_BYTE, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[1]  = '{OP_RD_BYTE, 1'b0, 8'h7F, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[2]  = '{OP_RD_BYTE, 1'b1, 8'hFF, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[3]  = '{OP_RD_BYTE, 1'b0, 8'h80, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[4]  = '{OP_WR_BYTE, 1'b0, 8'h30, 8'h00, 8'hA5, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[5]  = '{OP_RD_BYTE, 1'b0, 8'h30, 8'h00, 8'h00, 1'b0, 8'hA5, 1'b0, 1'b0};
    tbl[6]  = '{OP_WR_BYTE, 1'b0, 8'h90, 8'h00, 8'h11, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[7]  = '{OP_WR_BYTE, 1'b1, 8'h90, 8'h00, 8'h22, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[8]  = '{OP_RD_BYTE, 1'b0, 8'h90, 8'h00, 8'h00, 1'b0, 8'h11, 1'b0, 1'b0};
    tbl[9]  = '{OP_RD_BYTE, 1'b1, 8'h90, 8'h00, 8'h00, 1'b0, 8'h22, 1'b0, 1'b0};
    tbl[10] = '{OP_WR_BIT,  1'b0, 8'h00, 8'h0B, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0};
    tbl[11] = '{OP_RD_BYTE, 1'b0, 8'h21, 8'h00, 8'h00, 1'b0, 8'h08, 1'b0, 1'b0};
    tbl[12] = '{OP_WR_BIT,  1'b0, 8'h00, 8'hD7, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0};
    tbl[13] = '{OP_RD_BYTE, 1'b0, 8'hD0, 8'h00, 8'h00, 1'b0, 8'h80, 1'b0, 1'b0};
    tbl[14] = '{OP_RD_BIT,  1'b0, 8'h00, 8'hD7, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[15] = '{OP_RD_BIT,  1'b0, 8'h00, 8'h0A, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[16] = '{OP_WR_BYTE, 1'b0, 8'h2F, 8'h00, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[17] = '{OP_RD_BIT,  1'b0, 8'h00, 8'h7F, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[18] = '{OP_WR_BIT,  1'b0, 8'h00, 8'h7C, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[19] = '{OP_RD_BYTE, 1'b0, 8'h2F, 8'h00, 8'h00, 1'b0, 8'hEF, 1'b0, 1'b0};
    tbl[20] = '{OP_WR_BYTE, 1'b0, 8'h80, 8'h00, 8'h01, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[21] = '{OP_RD_BIT,  1'b0, 8'h00, 8'h80, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[22] = '{OP_RD_BYTE, 1'b1, 8'hA5, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[23] = '{OP_WR_BYTE, 1'b1, 8'h10, 8'h00, 8'h3C, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[24] = '{OP_RD_BYTE, 1'b0, 8'h10, 8'h00, 8'h00, 1'b0, 8'h3C, 1'b0, 1'b0};

    // Clock/reset
    reset = 1'b1; req1 = 1'b0; req2 = 1'b0; tgt = 1'b0;
    op = OP_RD_BYTE; indirect = 1'b0; addr = '0; bit_addr = '0; wdata = '0; wbit = 1'b0;
    @(posedge clock);
    @(negedge clock);
    chk_reset_outputs("por");
    reset = 1'b0;
    wait_init("por");

    for (int i = 0; i < 25; i++) begin
      do_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].ind, tbl[i].addr, tbl[i].baddr,
            tbl[i].wdata, tbl[i].wbit, tbl[i].exp_d, tbl[i].exp_b, tbl[i].exp_e);
    end

    // Back-to-back bit writes to 20h.0 and 20h.1 with req held across RMW.
    op = OP_WR_BIT; bit_addr = 8'h00; wbit = 1'b1; req1 = 1'b1;
    @(posedge clock);
    @(negedge clock);
    chk("b2b_first_rmw", 32'(ready1), 32'd0);
    bit_addr = 8'h01;
    @(posedge clock);
    @(negedge clock);
    chk("b2b_ready_again", 32'(ready1), 32'd1);
    @(posedge clock);
    @(negedge clock);
    req1 = 1'b0;
    chk("b2b_second_rmw", 32'(ready1), 32'd0);
    @(negedge clock);
    do_op("b2b_read20", OP_RD_BYTE, 1'b0, 8'h20, 8'h00, 8'h00, 1'b0, 8'h03, 1'b0, 1'b0);

    // Reset in the middle of a bit write to 20h.2.
    op = OP_WR_BIT; bit_addr = 8'h02; wbit = 1'b1; req1 = 1'b1;
    @(posedge clock);
    @(negedge clock);
    req1 = 1'b0;
    chk("midrst_in_rmw", 32'(state1), 32'(ST_RMW));
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    chk_reset_outputs("midrst");
    reset = 1'b0;
    wait_init("midrst");
    do_op("midrst_read20", OP_RD_BYTE, 1'b0, 8'h20, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    do_op("midrst_read30", OP_RD_BYTE, 1'b0, 8'h30, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    do_op("midrst_readD0", OP_RD_BYTE, 1'b0, 8'hD0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);

    // 128-byte build: no upper RAM.
    tgt = 1'b1;
    do_op("d128_rdC0", OP_RD_BYTE, 1'b1, 8'hC0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
    do_op("d128_wrC0", OP_WR_BYTE, 1'b1, 8'hC0, 8'h00, 8'h55, 1'b0, 8'h00, 1'b0, 1'b1);
    do_op("d128_rdC0b", OP_RD_BYTE, 1'b1, 8'hC0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
    do_op("d128_rd40", OP_RD_BYTE, 1'b0, 8'h40, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    do_op("d128_sfrC0", OP_RD_BYTE, 1'b0, 8'hC0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    do_op("d128_wr40", OP_WR_BYTE, 1'b1, 8'h40, 8'h00, 8'h5A, 1'b0, 8'h00, 1'b0, 1'b0);
    do_op("d128_rd40b", OP_RD_BYTE, 1'b1, 8'h40, 8'h00, 8'h00, 1'b0, 8'h5A, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/iram_ctrl.md
Name: iram_ctrl

Overview:
- Parametrised successor to the internal data memory for the 8051 core.
- Holds three byte-wide spaces:
  - lower RAM 00h-7Fh (direct and indirect);
  - upper RAM 80h-FFh (indirect only, optional);
  - SFR space 80h-FFh (direct only).
- Adds a req/ready handshake with fixed read latency, true 8051 bit-address decode, a 2-cycle read-modify-write bit-write FSM, a reset clear sweep, and an error flag for unimplemented locations.
- Sits between the core's decode/execute unit and storage.

Parameters:
- DATA_WIDTH, 8, byte width of every location.
- ADDR_WIDTH, 8, byte address width.
- IRAM_DEPTH, 256, total indirect RAM bytes. Legal values are 128 (no upper RAM) or 256.
- CLEAR_ON_RESET, 1. When 1, reset triggers the INIT sweep. When 0, the block goes straight to IDLE and contents are undefined.

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  1  request valid; sampled only when ready=1.
- op  in  2  operation code:
  - 00: byte read
  - 01: byte write
  - 10: bit read
  - 11: bit write
- indirect  in  1  byte ops only. 1 selects upper RAM for addr>=80h; 0 selects SFR.
- addr  in  ADDR_WIDTH  byte address; ignored for bit ops.
- bit_addr  in  8  8051 bit address; ignored for byte ops.
- wdata  in  DATA_WIDTH  byte write data.
- wbit  in  1  bit write data.
- ready  out  1  block can accept a request this cycle.
- rvalid  out  1  one-cycle pulse; rdata/rbit are valid.
- rdata  out  DATA_WIDTH  byte read result.
- rbit  out  1  bit read result.
- err  out  1  one-cycle pulse for an access to an unimplemented location.
- init_done  out  1  high once the clear sweep has finished.

Behaviour:
- Reset values:
  - ready=0, rvalid=0, rdata=0, rbit=0, err=0, init_done=0.
  - FSM goes to INIT, or to IDLE with init_done=1 when CLEAR_ON_RESET=0.
- FSM states: INIT, IDLE, RMW.
- INIT:
  - A clear counter writes 0 to one location per cycle: lower RAM, then upper RAM (if present), then all 128 SFR bytes.
  - Duration is IRAM_DEPTH+128 cycles (384 at default).
  - Last write -> IDLE; init_done=1 from the next cycle.
  - ready=0 throughout.
- IDLE:
  - ready=1.
  - A request is accepted on a clock edge where req=1.
- Byte address map:
  - addr<80h -> lower RAM[addr].
  - addr>=80h & indirect=0 -> SFR[addr].
  - addr>=80h & indirect=1 -> upper RAM[addr]. If IRAM_DEPTH=128: reads return 0, writes are dropped, err pulses.
- Bit address map:
  - bit_addr<80h -> byte 20h+bit_addr[6:3], bit bit_addr[2:0].
  - bit_addr>=80h -> SFR byte {bit_addr[7:3],3'b000}, bit bit_addr[2:0].
- Byte read / bit read:
  - rvalid, rdata/rbit (and err if applicable) are driven on the cycle after acceptance (latency 1).
  - For a byte read, rbit holds its previous value; for a bit read, rdata holds its previous value.
  - Back-to-back reads are accepted every cycle.
- Byte write:
  - Storage is updated at the accepting edge.
  - No rvalid.
  - Block stays in IDLE; the next request can follow immediately.
- Bit write:
  - Accept -> RMW; ready=0 for exactly one cycle.
  - RMW reads the target byte latched at acceptance, replaces one bit with wbit, writes it back, then -> IDLE.
  - Total occupancy is 2 cycles; no rvalid.
- Hazards:
  - A read issued the cycle after a write to the same byte returns the new value.
  - This holds for a bit read after a byte write, a byte read after a bit write, and bit writes to different bits of the same byte.
- Timing of outputs:
  - rvalid and err are single-cycle pulses and are never asserted in INIT.
  - err is asserted on the cycle after acceptance, the same cycle as rvalid for reads.
- Handshake boundaries:
  - req while ready=0 is ignored; the requester must hold req.
  - op, addr, bit_addr, wdata and wbit are sampled only at the accepting edge.
- Reset mid-operation (during RMW or INIT):
  - The pending write is abandoned.
  - All outputs go to reset values and INIT restarts from location 0.

Decomposition:
- Shared package iram_pkg:
  - op encodings OP_RD_BYTE, OP_WR_BYTE, OP_RD_BIT, OP_WR_BIT;
  - FSM state enum;
  - constants LRAM_TOP=7Fh, BIT_AREA_BASE=20h, SFR_BASE=80h.
- One natural sub-module, iram_addr_decode (combinational):
  - maps op/indirect/addr/bit_addr to {space select, byte index, bit index, unimplemented flag};
  - reused by the core for debug reads.

Test Plan:
- Reset held 1 cycle, then released:
  - ready=0 for 384 cycles, then ready=1 and init_done=1;
  - byte read of 00h, 7Fh, FFh (indirect=1) and 80h (indirect=0) all return 00h.
- Byte write A5h @30h, next cycle byte read @30h:
  - rdata=A5h with rvalid exactly one cycle after acceptance.
- Byte write 11h @90h with indirect=0, then byte write 22h @90h with indirect=1:
  - reading with indirect=0 returns 11h;
  - reading with indirect=1 returns 22h (independent spaces).
- Bit write wbit=1 to bit_addr 0Bh:
  - ready low for 1 cycle;
  - byte read @21h returns 08h;
  - bit write wbit=1 to bit_addr D7h, then byte read @D0h (indirect=0) returns 80h.
- Back-to-back bit writes to 20h.0 and 20h.1 (requester holds req across the RMW cycle):
  - byte read @20h returns 03h;
  - reset asserted during a following bit write -> INIT restarts and the location reads 00h afterwards.
- IRAM_DEPTH=128 build:
  - byte read @C0h with indirect=1 -> rdata=00h with err and rvalid both pulsing;
  - a write to the same location is dropped with err pulsing.
